pair_stream_tx: RTL and testbench

PAIR_STREAM_TX -- requirements
Module: pair_stream_tx

---
 rtl/pair_stream_pkg.sv | 27 ++
 rtl/pair_model.sv | 63 ++++++
 rtl/pair_stream_tx.sv | 111 +++++++++++
 tb/tb_pair_stream_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_stream_pkg.sv
// Shared types and constants for the pair stream transmitter.
// Holds the serializer FSM states, the pair detector model states and the
// saturation limit used by the optional pair counter.
package pair_stream_pkg;

  // Serializer control states
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_t;

  // Pair detector model states: no pending bit, pending one, pending zero
  typedef enum logic [1:0] {
    M_NONE = 2'd0,
    M_ONE  = 2'd1,
    M_ZERO = 2'd2
  } model_state_t;

  // Ceiling for the pair counter
  localparam logic [15:0] PAIR_COUNT_MAX = 16'hFFFF;

  // Increment that sticks at PAIR_COUNT_MAX instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == PAIR_COUNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pair_model.sv
// Reference model of a pair detector.
// Watches a serial bit stream and pulses pair_pulse one cycle after any bit
// that completes a pair of equal bits. Pairs never overlap: once a pair is
// complete the model forgets both bits. Only cycles with bit_valid=1 advance
// the model, so gaps in the stream of any length are invisible to it.
module pair_model
  import pair_stream_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic bit_valid,
  input  logic bit_in,
  output logic pair_pulse
);

  model_state_t state;
  model_state_t state_n;
  logic         pulse_n;

  // Register the model state and the pair pulse so the pulse lines up with a registered detector output
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= M_NONE;
      pair_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      pair_pulse <= pulse_n;
    end
  end

  // Decide the next model state and whether the current bit closes a pair
  always_comb begin
    state_n = state;
    pulse_n = 1'b0;
    if (bit_valid) begin
      case (state)
        M_NONE: begin
          state_n = bit_in ? M_ONE : M_ZERO;
        end
        M_ONE: begin
          if (bit_in) begin
            pulse_n = 1'b1;
            state_n = M_NONE;
          end else begin
            state_n = M_ZERO;
          end
        end
        M_ZERO: begin
          if (!bit_in) begin
            pulse_n = 1'b1;
            state_n = M_NONE;
          end else begin
            state_n = M_ONE;
          end
        end
        default: begin
          state_n = M_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pair_stream_tx.sv
// Parallel-to-serial transmitter with a built-in pair detector model.
// Words are accepted with a valid/ready handshake and shifted out MSB-first,
// one bit per cycle, starting the cycle after acceptance. A new word can be
// accepted in the cycle that emits the last bit of the current word, so
// back-to-back words stream without a bubble. pair_exp predicts what a
// registered pair detector on ser_out would report.
// Optional feature: define PAIR_STREAM_TX_COUNT_EN to add the saturating
// 16-bit pair_count output.
module pair_stream_tx
  import pair_stream_pkg::*;
#(
  parameter int WIDTH = 8
)
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             pair_exp
`ifdef PAIR_STREAM_TX_COUNT_EN
  ,
  output logic [15:0]      pair_count
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  tx_state_t        state;
  tx_state_t        state_n;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_reg_n;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_n;

  // Hold the serializer state, the word in flight and the bit position
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_reg_n;
      bit_cnt   <= bit_cnt_n;
    end
  end

  // Handshake, shifting and output decode; ready only opens on the last bit so the word in flight is never overwritten
  always_comb begin
    state_n     = state;
    shift_reg_n = shift_reg;
    bit_cnt_n   = bit_cnt;
    data_ready  = 1'b0;
    ser_valid   = 1'b0;
    ser_out     = 1'b0;
    case (state)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          shift_reg_n = data_in;
          bit_cnt_n   = '0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = shift_reg[WIDTH-1];
        if (bit_cnt == LAST_BIT) begin
          data_ready = 1'b1;
          bit_cnt_n  = '0;
          if (data_valid) begin
            shift_reg_n = data_in;
          end else begin
            shift_reg_n = {shift_reg[WIDTH-2:0], 1'b0};
            state_n     = IDLE;
          end
        end else begin
          shift_reg_n = {shift_reg[WIDTH-2:0], 1'b0};
          bit_cnt_n   = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  pair_model u_model (
    .clock      (clock),
    .reset      (reset),
    .bit_valid  (ser_valid),
    .bit_in     (ser_out),
    .pair_pulse (pair_exp)
  );

`ifdef PAIR_STREAM_TX_COUNT_EN
  // Count pair pulses since reset, sticking at the maximum rather than wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      pair_count <= '0;
    end else if (pair_exp) begin
      pair_count <= sat_inc16(pair_count);
    end
  end
`endif

endmodule

// File: tb/tb_pair_stream_tx.sv
// Testbench for pair_stream_tx.
// A driver issues one cycle of stimulus at a time and keeps a word-level
// model: accepted words are expanded into a queue of expected bits, each
// tagged with whether it closes a pair. A monitor on the falling edge pops
// and compares whenever the DUT shows ser_valid.
module tb_pair_stream_tx;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             pair_exp;
`ifdef PAIR_STREAM_TX_COUNT_EN
  logic [15:0]      pair_count;
`endif

  always #5 clock = ~clock;

  pair_stream_tx #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .pair_exp   (pair_exp)
`ifdef PAIR_STREAM_TX_COUNT_EN
    ,
    .pair_count (pair_count)
`endif
  );

  typedef struct packed {
    logic b;
    logic pair;
  } bit_exp_t;

  typedef struct packed {
    logic ready;
    logic valid;
    logic rst;
  } cyc_exp_t;

  bit_exp_t bitQ[$];
  cyc_exp_t cycQ[$];

  int   bitsLeft;
  int   pend;
  int   checks;
  int   errors;
  int   pulsesSeen;
  int   expCnt;
  int   base;
  logic prevPair;
  logic accepted;

  cyc_exp_t monC;
  bit_exp_t monE;
  logic     monNext;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle of stimulus; the word-level model decides ready and what gets accepted
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    cyc_exp_t c;
    logic     emitting;
    logic     rdy;
    logic     hs;
    @(posedge clock);
    #1;
    data_valid = v;
    data_in    = d;
    reset      = r;
    emitting   = (bitsLeft > 0);
    rdy        = (bitsLeft <= 1);
    c.ready    = rdy;
    c.valid    = emitting;
    c.rst      = r;
    cycQ.push_back(c);
    hs       = v && rdy && !r;
    accepted = hs;
    if (emitting) bitsLeft--;
    if (hs) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        bit_exp_t e;
        e.b = d[i];
        if (pend == int'(d[i])) begin
          e.pair = 1'b1;
          pend   = -1;
        end else begin
          e.pair = 1'b0;
          pend   = int'(d[i]);
        end
        bitQ.push_back(e);
      end
      bitsLeft += WIDTH;
    end
    if (r) begin
      bitsLeft = 0;
      pend     = -1;
    end
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, w, 1'b0);
      n++;
    end while (!accepted && n < 2 * WIDTH + 4);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, WIDTH'($urandom), 1'b0);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  // Monitor: compare control outputs every cycle and pop expected bits whenever the DUT shows one
  always @(negedge clock) begin
    if (cycQ.size() > 0) begin
      monC = cycQ.pop_front();
      checkOutput("data_ready", 32'(data_ready), 32'(monC.ready));
      checkOutput("ser_valid", 32'(ser_valid), 32'(monC.valid));
      checkOutput("pair_exp", 32'(pair_exp), 32'(prevPair));
`ifdef PAIR_STREAM_TX_COUNT_EN
      checkOutput("pair_count", 32'(pair_count), 32'(expCnt));
      if (prevPair && expCnt < 65535) expCnt++;
`endif
      if (pair_exp === 1'b1) pulsesSeen++;
      monNext = 1'b0;
      if (ser_valid === 1'b1) begin
        if (bitQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL ser_unexpected: got ser_valid=1 expected no pending bits at %0t", $time);
        end else begin
          monE = bitQ.pop_front();
          checkOutput("ser_out", 32'(ser_out), 32'(monE.b));
          monNext = monE.pair;
        end
      end else begin
        checkOutput("ser_out_idle", 32'(ser_out), 32'd0);
      end
      if (monC.rst) begin
        bitQ.delete();
        monNext = 1'b0;
        expCnt  = 0;
      end
      prevPair = monNext;
    end
  end

  initial begin
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    bitsLeft   = 0;
    pend       = -1;
    checks     = 0;
    errors     = 0;
    pulsesSeen = 0;
    expCnt     = 0;
    prevPair   = 1'b0;
    accepted   = 1'b0;
    repeat (3) @(posedge clock);

    // 0xCC: four pulses
    base = pulsesSeen;
    sendWord(8'hCC);
    idleCycles(WIDTH + 3);
    checkOutput("cc_pulses", 32'(pulsesSeen - base), 32'd4);

    // 0xAA yields no pulse and leaves a pending zero that pairs with the next word's leading 0
    resetCycle();
    base = pulsesSeen;
    sendWord(8'hAA);
    idleCycles(WIDTH + 3);
    checkOutput("aa_pulses", 32'(pulsesSeen - base), 32'd0);
    idleCycles(5);
    base = pulsesSeen;
    sendWord(8'h7F);
    idleCycles(WIDTH + 3);
    checkOutput("aa_7f_pulses", 32'(pulsesSeen - base), 32'd4);

    // 0x80 then 0x00 back to back: seven pulses, one across the boundary
    resetCycle();
    base = pulsesSeen;
    sendWord(8'h80);
    sendWord(8'h00);
    idleCycles(WIDTH + 3);
    checkOutput("b2b_pulses", 32'(pulsesSeen - base), 32'd7);
`ifdef PAIR_STREAM_TX_COUNT_EN
    checkOutput("b2b_count", 32'(pair_count), 32'd7);
`endif

    // Reset on the 4th bit of 0xFF, then 0x0F
    resetCycle();
    base = pulsesSeen;
    sendWord(8'hFF);
    idleCycles(3);
    resetCycle();
    idleCycles(2);
    checkOutput("ff_reset_pulses", 32'(pulsesSeen - base), 32'd1);
    base = pulsesSeen;
    sendWord(8'h0F);
    idleCycles(WIDTH + 3);
    checkOutput("0f_pulses", 32'(pulsesSeen - base), 32'd4);

    // data_valid toggling with changing data while a word is in flight
    sendWord(8'hA5);
    for (int i = 0; i < 12; i++) applyStimulus(1'(i % 2), WIDTH'($urandom), 1'b0);
    idleCycles(WIDTH + 3);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 9) < 6), WIDTH'($urandom), ($urandom_range(0, 49) == 0));
    end
    idleCycles(WIDTH + 3);
    checkOutput("bitq_empty", 32'(bitQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
